// File: rtl/seat_resv_ctrl_if.sv
// rtl/seat_resv_ctrl_if.sv - request/response, timer and status bundle for the seat reservation controller
interface seat_resv_ctrl_if;
    logic [10:0] time_in;
    logic        day_clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [3:0]  req_seat;
    logic [7:0]  req_dur;
    logic        resp_valid;
    logic        resp_ok;
    logic [3:0]  resp_seat;
    logic [15:0] occ_map;
    logic [4:0]  free_cnt;
    logic        expire_valid;
    logic [3:0]  expire_seat;

    modport master (
        output time_in, day_clr, req_valid, req_op, req_seat, req_dur,
        input  req_ready, resp_valid, resp_ok, resp_seat, occ_map, free_cnt,
               expire_valid, expire_seat
    );

    modport slave (
        input  time_in, day_clr, req_valid, req_op, req_seat, req_dur,
        output req_ready, resp_valid, resp_ok, resp_seat, occ_map, free_cnt,
               expire_valid, expire_seat
    );
endinterface

// File: rtl/seat_resv_ctrl.sv
// rtl/seat_resv_ctrl.sv - seat reservation table with timed expiry sweep and daily clear
module seat_resv_ctrl #(
    parameter int NSEAT   = 16,
    parameter int MAX_DUR = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    seat_resv_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_CLEAR} state_t;

    localparam logic [10:0] LAST_MIN  = 11'd1439;
    localparam logic [7:0]  MAX_DUR_W = 8'(MAX_DUR);

    state_t            state_q;
    logic [10:0]       time_q, now_q;
    logic              sweep_pend_q, clr_pend_q, day_clr_q;
    logic [3:0]        idx_q;
    logic [NSEAT-1:0]  occ_q, occ_d;
    logic [10:0]       end_q [NSEAT];
    logic [10:0]       end_d [NSEAT];
    logic [4:0]        free_q, free_d;
    logic              resp_valid_q, resp_ok_q, expire_valid_q;
    logic [3:0]        resp_seat_q, expire_seat_q;

    logic        time_ok, time_chg, clr_edge, ready, accept;
    logic        dur_ok, seat_occ, req_ok, sweep_hit;
    logic [10:0] new_now, end_clamp;
    logic [11:0] end_sum;

    assign time_ok   = (bus.time_in[10:6] <= 5'd23) && (bus.time_in[5:0] <= 6'd59);
    assign time_chg  = time_ok && (bus.time_in != time_q);
    assign clr_edge  = bus.day_clr && !day_clr_q;
    assign new_now   = {6'd0, bus.time_in[10:6]} * 11'd60 + {5'd0, bus.time_in[5:0]};

    // Ready depends on registered state only, so req_* never reaches req_ready.
    assign ready     = (state_q == S_IDLE) && !clr_pend_q && !sweep_pend_q;
    assign accept    = bus.req_valid && ready;

    assign end_sum   = {1'b0, now_q} + {4'd0, bus.req_dur};
    assign end_clamp = (end_sum > {1'b0, LAST_MIN}) ? LAST_MIN : end_sum[10:0];
    assign dur_ok    = (bus.req_dur != 8'd0) && (bus.req_dur <= MAX_DUR_W);
    assign seat_occ  = occ_q[bus.req_seat];
    assign req_ok    = bus.req_op ? seat_occ : (!seat_occ && dur_ok);

    // A pending clear wins over the seat the sweep would have visited this cycle.
    assign sweep_hit = (state_q == S_SWEEP) && !clr_pend_q && occ_q[idx_q]
                       && (end_q[idx_q] <= now_q);

    always_comb begin
        occ_d = occ_q;
        end_d = end_q;
        if (state_q == S_CLEAR) begin
            occ_d = '0;
        end else if (sweep_hit) begin
            occ_d[idx_q] = 1'b0;
        end else if (accept && req_ok) begin
            if (bus.req_op) begin
                occ_d[bus.req_seat] = 1'b0;
            end else begin
                occ_d[bus.req_seat] = 1'b1;
                end_d[bus.req_seat] = end_clamp;
            end
        end
    end

    assign free_d = 5'(NSEAT) - 5'($countones(occ_d));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            time_q         <= '0;
            now_q          <= '0;
            sweep_pend_q   <= 1'b0;
            clr_pend_q     <= 1'b0;
            day_clr_q      <= 1'b0;
            idx_q          <= '0;
            occ_q          <= '0;
            for (int i = 0; i < NSEAT; i++) end_q[i] <= '0;
            free_q         <= 5'(NSEAT);
            resp_valid_q   <= 1'b0;
            resp_ok_q      <= 1'b0;
            resp_seat_q    <= '0;
            expire_valid_q <= 1'b0;
            expire_seat_q  <= '0;
        end else begin
            occ_q     <= occ_d;
            end_q     <= end_d;
            free_q    <= free_d;
            day_clr_q <= bus.day_clr;

            if (time_chg) begin
                time_q <= bus.time_in;
                now_q  <= new_now;
            end

            resp_valid_q <= accept;
            if (accept) begin
                resp_ok_q   <= req_ok;
                resp_seat_q <= bus.req_seat;
            end

            expire_valid_q <= sweep_hit;
            if (sweep_hit) expire_seat_q <= idx_q;

            if (clr_edge)                 clr_pend_q <= 1'b1;
            else if (state_q == S_CLEAR)  clr_pend_q <= 1'b0;

            if (time_chg)
                sweep_pend_q <= 1'b1;
            else if (state_q == S_IDLE && !clr_pend_q)
                sweep_pend_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (clr_pend_q) begin
                        state_q <= S_CLEAR;
                    end else if (sweep_pend_q) begin
                        state_q <= S_SWEEP;
                        idx_q   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (clr_pend_q) begin
                        state_q <= S_CLEAR;
                    end else begin
                        if (idx_q == 4'(NSEAT - 1)) state_q <= S_IDLE;
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_CLEAR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_ok      = resp_ok_q;
    assign bus.resp_seat    = resp_seat_q;
    assign bus.occ_map      = occ_q;
    assign bus.free_cnt     = free_q;
    assign bus.expire_valid = expire_valid_q;
    assign bus.expire_seat  = expire_seat_q;
endmodule

// File: tb/tb_seat_resv_ctrl.sv
// tb/tb_seat_resv_ctrl.sv - table vectors, corner sequences and random traffic against a seat-table model
module tb_seat_resv_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seat_resv_ctrl_if bus();

    seat_resv_ctrl #(.NSEAT(16), .MAX_DUR(240)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          op;
        int          seat;
        int          dur;
        bit          ok;
        logic [15:0] occ;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] occ_m;
    int          end_m [16];
    int          now_m;
    int          cur_h, cur_m;
    int          exp_q[$];
    int          got[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_req(input bit op, input int s, input int dur);
        if (op) begin
            if (occ_m[s]) begin
                occ_m[s] = 1'b0;
                return 1'b1;
            end
            return 1'b0;
        end
        if (!occ_m[s] && dur >= 1 && dur <= 240) begin
            occ_m[s] = 1'b1;
            end_m[s] = (now_m + dur > 1439) ? 1439 : now_m + dur;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_time(input int h, input int m);
        exp_q.delete();
        now_m = h * 60 + m;
        cur_h = h;
        cur_m = m;
        for (int s = 0; s < 16; s++) begin
            if (occ_m[s] && end_m[s] <= now_m) begin
                exp_q.push_back(s);
                occ_m[s] = 1'b0;
            end
        end
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        chk({name, "_ready"}, int'(bus.req_ready), 1);
    endtask

    task automatic do_req(input bit op, input int s, input int dur,
                          output bit ok, output logic [15:0] occ);
        wait_ready("req");
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_seat  = s[3:0];
        bus.req_dur   = dur[7:0];
        step();
        bus.req_valid = 1'b0;
        chk("resp_valid", int'(bus.resp_valid), 1);
        chk("resp_seat", int'(bus.resp_seat), s);
        ok  = bus.resp_ok;
        occ = bus.occ_map;
        step();
        chk("resp_one_cycle", int'(bus.resp_valid), 0);
    endtask

    task automatic collect(input string name, output int gap, output int low);
        bit seen_low = 1'b0;
        int last = -1;
        int cyc;
        low = 0;
        got.delete();
        for (cyc = 0; cyc < 60; cyc++) begin
            step();
            if (bus.expire_valid) begin
                got.push_back(int'(bus.expire_seat));
                last = cyc;
            end
            if (!bus.req_ready) begin
                low++;
                seen_low = 1'b1;
            end else if (seen_low) begin
                break;
            end
        end
        chk({name, "_sweep_done"}, int'(seen_low && bus.req_ready), 1);
        gap = (last >= 0) ? cyc - last : -1;
        chk({name, "_expire_cnt"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({name, "_expire_seat"}, got[i], exp_q[i]);
        chk({name, "_occ"}, int'(bus.occ_map), int'(occ_m));
        chk({name, "_free"}, int'(bus.free_cnt), 16 - $countones(occ_m));
    endtask

    task automatic set_time(input int h, input int m, input string name,
                            output int gap, output int low);
        model_time(h, m);
        bus.time_in = 11'(h * 64 + m);
        collect(name, gap, low);
    endtask

    initial begin
        vec_t        tbl [10];
        bit          ok, e;
        logic [15:0] occ;
        int          gap, low, cnt, h, m, r, s, dur;
        bit          raised, seen_low;
        int          cyc;

        tbl[0] = '{1'b0,  3,  30, 1'b1, 16'h0008};
        tbl[1] = '{1'b0,  5, 100, 1'b1, 16'h0028};
        tbl[2] = '{1'b0,  5,  10, 1'b0, 16'h0028};
        tbl[3] = '{1'b0,  7,   0, 1'b0, 16'h0028};
        tbl[4] = '{1'b0,  7, 241, 1'b0, 16'h0028};
        tbl[5] = '{1'b0,  7, 240, 1'b1, 16'h00A8};
        tbl[6] = '{1'b1,  9,   0, 1'b0, 16'h00A8};
        tbl[7] = '{1'b1,  7,   0, 1'b1, 16'h0028};
        tbl[8] = '{1'b0, 15,   1, 1'b1, 16'h8028};
        tbl[9] = '{1'b1, 15,   0, 1'b1, 16'h0028};

        rst_n = 1'b0;
        bus.time_in = '0; bus.day_clr = 1'b0; bus.req_valid = 1'b0;
        bus.req_op = 1'b0; bus.req_seat = '0; bus.req_dur = '0;
        occ_m = '0; now_m = 0; cur_h = 0; cur_m = 0;
        for (int i = 0; i < 16; i++) end_m[i] = 0;
        step();
        step();
        chk("rst_occ", int'(bus.occ_map), 0);
        chk("rst_free", int'(bus.free_cnt), 16);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_expire_valid", int'(bus.expire_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(bus.req_ready), 1);

        set_time(8, 0, "t0800", gap, low);
        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i].op, tbl[i].seat, tbl[i].dur, ok, occ);
            e = model_req(tbl[i].op, tbl[i].seat, tbl[i].dur);
            chk("tbl_ok", int'(ok), int'(tbl[i].ok));
            chk("tbl_occ", int'(occ), int'(tbl[i].occ));
            chk("tbl_free", int'(bus.free_cnt), 16 - $countones(tbl[i].occ));
        end

        set_time(8, 30, "t0830", gap, low);
        chk("t0830_occ_const", int'(bus.occ_map), 16'h0020);
        chk("t0830_expire_to_idle", gap, 12);
        chk("t0830_ready_low_len", int'(low >= 16 && low <= 17), 1);

        set_time(23, 50, "t2350", gap, low);
        do_req(1'b0, 0, 60, ok, occ);
        e = model_req(1'b0, 0, 60);
        chk("late_resv_ok", int'(ok), 1);
        set_time(23, 58, "t2358", gap, low);
        chk("t2358_no_expire", got.size(), 0);
        set_time(23, 59, "t2359", gap, low);
        chk("t2359_expire_seat0", (got.size() == 1) ? got[0] : -1, 0);

        bus.time_in = 11'(24 * 64);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!bus.req_ready || bus.expire_valid) cnt++;
        end
        bus.time_in = 11'(10 * 64 + 60);
        for (int i = 0; i < 4; i++) begin
            step();
            if (!bus.req_ready || bus.expire_valid) cnt++;
        end
        chk("invalid_time_ignored", cnt, 0);
        bus.time_in = 11'(cur_h * 64 + cur_m);
        step();

        set_time(1, 0, "t0100", gap, low);
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, i, 240, ok, occ);
            e = model_req(1'b0, i, 240);
            chk("fill_ok", int'(ok), int'(e));
        end
        chk("fill_free", int'(bus.free_cnt), 0);

        bus.time_in = 11'(6 * 64);
        got.delete();
        raised = 1'b0;
        seen_low = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            step();
            if (bus.expire_valid) begin
                got.push_back(int'(bus.expire_seat));
                if (bus.expire_seat == 4'd6 && !raised) begin
                    bus.day_clr = 1'b1;
                    raised = 1'b1;
                end
            end
            if (!bus.req_ready) seen_low = 1'b1;
            else if (seen_low) break;
        end
        chk("abort_done", int'(seen_low && bus.req_ready), 1);
        chk("abort_expire_cnt", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("abort_expire_seat", got[i], i);
        chk("abort_occ", int'(bus.occ_map), 0);
        chk("abort_free", int'(bus.free_cnt), 16);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.expire_valid) cnt++;
        end
        chk("abort_no_more_expire", cnt, 0);
        bus.day_clr = 1'b0;
        occ_m = '0;
        now_m = 360; cur_h = 6; cur_m = 0;

        wait_ready("same_cycle");
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_seat = 4'd10; bus.req_dur = 8'd5;
        bus.time_in = 11'(6 * 64 + 10);
        e = model_req(1'b0, 10, 5);
        model_time(6, 10);
        step();
        bus.req_valid = 1'b0;
        chk("same_cycle_resp_valid", int'(bus.resp_valid), 1);
        chk("same_cycle_resp_ok", int'(bus.resp_ok), int'(e));
        chk("same_cycle_resp_seat", int'(bus.resp_seat), 10);
        collect("same_cycle", gap, low);

        do_req(1'b0, 12, 10, ok, occ);
        e = model_req(1'b0, 12, 10);
        bus.time_in = 11'(7 * 64);
        for (int i = 0; i < 5; i++) step();
        chk("mid_sweep_busy", int'(bus.req_ready), 0);
        rst_n = 1'b0;
        bus.time_in = '0;
        step();
        step();
        chk("mrst_occ", int'(bus.occ_map), 0);
        chk("mrst_free", int'(bus.free_cnt), 16);
        chk("mrst_resp_valid", int'(bus.resp_valid), 0);
        chk("mrst_resp_ok", int'(bus.resp_ok), 0);
        chk("mrst_resp_seat", int'(bus.resp_seat), 0);
        chk("mrst_expire_valid", int'(bus.expire_valid), 0);
        chk("mrst_expire_seat", int'(bus.expire_seat), 0);
        rst_n = 1'b1;
        #1;
        chk("mrst_ready", int'(bus.req_ready), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.expire_valid || bus.resp_valid || !bus.req_ready) cnt++;
        end
        chk("mrst_quiet", cnt, 0);
        occ_m = '0; now_m = 0; cur_h = 0; cur_m = 0;
        for (int i = 0; i < 16; i++) end_m[i] = 0;

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                s   = $urandom_range(0, 15);
                dur = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(1, 240);
                r   = $urandom_range(0, 2);
                do_req(r == 0, s, dur, ok, occ);
                e = model_req(r == 0, s, dur);
                chk("rnd_ok", int'(ok), int'(e));
                chk("rnd_occ", int'(occ), int'(occ_m));
                chk("rnd_free", int'(bus.free_cnt), 16 - $countones(occ_m));
            end else begin
                h = $urandom_range(0, 23);
                m = $urandom_range(0, 59);
                if (h == cur_h && m == cur_m) m = (m + 1) % 60;
                set_time(h, m, "rnd_time", gap, low);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seat_resv_ctrl.md
SEAT_RESV_CTRL -- requirements
Module: seat_resv_ctrl

Interface
REQ-001 SHALL have parameter NSEAT, default 16, number of managed seats (fixed at 16 for this release).
REQ-002 SHALL have parameter MAX_DUR, default 240, largest legal reservation length in minutes.
REQ-003 SHALL have port clk  in  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port time_in  in  11  current time of day from the timer stage: [10:6] hour 0-23, [5:0] minute 0-59.
REQ-006 SHALL have port day_clr  in  1  daily-clear level from the timer stage; its rising edge requests clear-all.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  block can accept a request this cycle.
REQ-009 SHALL have port req_op  in  1  0 = reserve, 1 = release.
REQ-010 SHALL have port req_seat  in  4  target seat index.
REQ-011 SHALL have port req_dur  in  8  reservation length in minutes; ignored on release.
REQ-012 SHALL have port resp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port resp_ok  out  1  request succeeded; qualified by resp_valid.
REQ-014 SHALL have port resp_seat  out  4  seat index of the response.
REQ-015 SHALL have port occ_map  out  16  bit i = seat i occupied.
REQ-016 SHALL have port free_cnt  out  5  count of unoccupied seats.
REQ-017 SHALL have port expire_valid  out  1  one-cycle pulse: a seat timed out.
REQ-018 SHALL have port expire_seat  out  4  index of the expired seat; qualified by expire_valid.

Function
REQ-019 SHALL convert time to minutes-of-day: now = hour*60 + minute, range 0-1439, 11-bit unsigned.
REQ-020 SHALL register time_in each cycle; a valid value (hour<=23, minute<=59) differing from the stored value SHALL update now and set sweep_pend; invalid values SHALL be ignored (now unchanged, no sweep).
REQ-021 SHALL register day_clr and detect its 0->1 transition as clr_pend.
REQ-022 SHALL implement FSM states IDLE, SWEEP, CLEAR.
REQ-023 IDLE: clr_pend -> CLEAR; else sweep_pend -> SWEEP with index 0, clearing sweep_pend; else serve requests.
REQ-024 CLEAR SHALL last one cycle: occ_map = 0, free_cnt = NSEAT, clr_pend cleared, no expire pulses, then IDLE; clr_pend set during SWEEP SHALL abort the sweep and enter CLEAR next cycle.
REQ-025 SWEEP SHALL visit one seat per cycle, indices 0..NSEAT-1 (16 cycles); for an occupied seat with end_time <= now it SHALL clear the seat and pulse expire_valid with expire_seat = index in the same cycle the bit clears.
REQ-026 A time change during SWEEP SHALL set sweep_pend; the running sweep completes using the updated now from that cycle on, and a new full sweep starts after return to IDLE.
REQ-027 req_ready SHALL be 1 only when state = IDLE and clr_pend = 0 and sweep_pend = 0, decoded from registers only (no combinational path from req_* inputs).
REQ-028 A request SHALL be accepted in the cycle req_valid = req_ready = 1; resp_valid pulses exactly one cycle later with resp_seat = accepted req_seat.
REQ-029 Reserve SHALL succeed iff seat unoccupied and 1 <= req_dur <= MAX_DUR; on success set occ bit and end_time = min(now + req_dur, 1439), 12-bit intermediate sum.
REQ-030 Release SHALL succeed iff seat occupied; on success clear occ bit; failure leaves state unchanged.
REQ-031 occ_map and free_cnt SHALL update in the same cycle; free_cnt = NSEAT - popcount(occ_map) at all times.
REQ-032 A request accepted in the cycle a time change or day_clr edge is detected SHALL complete normally; the sweep/clear begins the following cycle.

Reset
REQ-033 rst_n = 0 at a rising edge SHALL force: state IDLE, occ_map 0, all end_time 0, free_cnt 16, resp_valid 0, resp_ok 0, resp_seat 0, expire_valid 0, expire_seat 0, stored time 0, now 0, sweep_pend 0, clr_pend 0, stored day_clr 0.
REQ-034 Reset asserted mid-SWEEP or mid-handshake SHALL discard the operation with no response or expire pulse issued afterward.
REQ-035 req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-036 time 08:00, reserve seat 3 dur 30 -> resp_ok 1 one cycle later, occ_map 0x0008, free_cnt 15.
REQ-037 seat 3 held to 08:30; time_in steps to 08:30 -> SWEEP, expire_valid with expire_seat 3 at sweep cycle 4, occ_map 0x0000, req_ready low 16 cycles.
REQ-038 reserve seat 5 twice -> first resp_ok 1, second resp_ok 0; dur 0 or 241 -> resp_ok 0, occ_map unchanged.
REQ-039 time 23:50, reserve seat 0 dur 60 -> end_time 1439; no expiry until time_in 23:59.
REQ-040 seats 0-15 occupied, day_clr rises at sweep index 7 -> sweep aborted, CLEAR, occ_map 0, free_cnt 16, no further expire pulses.
REQ-041 rst_n low mid-SWEEP -> all outputs at reset values, req_ready 1 after release.
